// File: rtl/store_exec_unit.sv
// Execute-stage store unit: forms EA, steers SB/SH/SW data onto the dmem write port, req/ack with timeout.
// Optional feature macro: STORE_MISALIGN_CHECK_EN aborts misaligned SH/SW with st_err instead of aligning down.
`ifndef STR_NOP
`define STR_NOP 3'b000
`define SB      3'b001
`define SH      3'b010
`define SW      3'b011
`endif

module store_exec_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [2:0]  store_control,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [11:0] imm,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  output logic        st_done,
  output logic        st_err
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [31:0]   addr_q, wdata_q;
  logic [3:0]    be_q;

  logic [31:0]   ea, wd_n;
  logic [3:0]    be_n;
  logic          is_mem, go_req, abort_err, accept, tmo;

  assign ea     = rs1_data + {{20{imm[11]}}, imm};
  assign accept = st_valid && (state_q == IDLE);

  always_comb begin
    be_n   = 4'b0000;
    wd_n   = 32'h0;
    is_mem = 1'b0;
    case (store_control)
      `SB: begin be_n = 4'b0001 << ea[1:0];         wd_n = {4{rs2_data[7:0]}};  is_mem = 1'b1; end
      `SH: begin be_n = 4'b0011 << {ea[1], 1'b0};   wd_n = {2{rs2_data[15:0]}}; is_mem = 1'b1; end
      `SW: begin be_n = 4'b1111;                    wd_n = rs2_data;            is_mem = 1'b1; end
      default: ;
    endcase
  end

`ifdef STORE_MISALIGN_CHECK_EN
  logic misal;
  always_comb begin
    misal = 1'b0;
    if (store_control == `SH) misal = ea[0];
    if (store_control == `SW) misal = |ea[1:0];
  end
  assign go_req    = is_mem && !misal;
  assign abort_err = is_mem && misal;
`else
  assign go_req    = is_mem;
  assign abort_err = 1'b0;
`endif

  // Counter value one short of the limit means this REQ cycle is the last one allowed.
  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (st_valid) begin
          state_d = go_req ? REQ : DONE;
          err_d   = abort_err;
        end
      end
      REQ: begin
        if (dmem_ack) begin
          state_d = DONE;
          err_d   = 1'b0;
        end else if (tmo) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else if (TIMEOUT_CYCLES != 0) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
      if (accept) begin
        addr_q  <= {ea[31:2], 2'b00};
        wdata_q <= wd_n;
        be_q    <= be_n;
      end
    end
  end

  always_comb begin
    st_ready   = (state_q == IDLE);
    dmem_req   = (state_q == REQ);
    dmem_addr  = addr_q;
    dmem_be    = dmem_req ? be_q : 4'b0000;
    dmem_wdata = dmem_req ? wdata_q : 32'h0;
    st_done    = (state_q == DONE);
    st_err     = (state_q == DONE) && err_q;
  end
endmodule

// File: tb/tb_store_exec_unit.sv
// Directed + random bench for store_exec_unit against a lane-by-lane reference model.
`ifndef STR_NOP
`define STR_NOP 3'b000
`define SB      3'b001
`define SH      3'b010
`define SW      3'b011
`endif

module tb_store_exec_unit;
  localparam int TO = 4;

  logic        clk = 1'b0, rst = 1'b1, st_valid = 1'b0, dmem_ack = 1'b0;
  logic [2:0]  store_control = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0;
  logic [11:0] imm = '0;
  logic        st_ready, dmem_req, st_done, st_err;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  int tests = 0, fails = 0;

  store_exec_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .st_valid(st_valid), .st_ready(st_ready),
    .store_control(store_control), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack), .st_done(st_done), .st_err(st_err)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: a store of `size` bytes covers lanes [start, start+size) of the word holding ea.
  task automatic model(input logic [2:0] c, input logic [31:0] r1, r2, input logic [11:0] im,
                       output bit go, output bit abort, output logic [31:0] a, w,
                       output logic [3:0] be);
    logic [31:0] ea;
    int size, off, start;
    ea = r1 + 32'($signed(im));
    size = (c == `SB) ? 1 : (c == `SH) ? 2 : (c == `SW) ? 4 : 0;
    off = int'(ea % 4);
    a = ea - 32'(off);
    be = '0; w = '0; go = 0; abort = 0;
    if (size != 0) begin
      start = off - (off % size);
      for (int i = 0; i < 4; i++) begin
        be[i] = (i >= start) && (i < start + size);
        w[8*i +: 8] = r2[8*(i % size) +: 8];
      end
      go = 1;
`ifdef STORE_MISALIGN_CHECK_EN
      if ((off % size) != 0) begin go = 0; abort = 1; end
`endif
    end
  endtask

  task automatic do_store(input logic [2:0] c, input logic [31:0] r1, r2, input logic [11:0] im,
                          input int dly);
    bit go, abort, acked;
    logic [31:0] ea_w, wd;
    logic [3:0] be;
    model(c, r1, r2, im, go, abort, ea_w, wd, be);
    @(negedge clk);
    check("ready_idle", 32'(st_ready), 32'd1);
    check("req_idle", 32'(dmem_req), 32'd0);
    st_valid = 1; store_control = c; rs1_data = r1; rs2_data = r2; imm = im;
    @(negedge clk);
    // Inputs change freely outside IDLE and must not disturb the op in flight.
    st_valid = 1; store_control = 3'($urandom); rs1_data = $urandom; rs2_data = $urandom;
    imm = 12'($urandom);
    if (!go) begin
      check("nop_req", 32'(dmem_req), 32'd0);
      check("nop_done", 32'(st_done), 32'd1);
      check("nop_err", 32'(st_err), 32'(abort));
    end else begin
      acked = 0;
      for (int k = 0; k < TO; k++) begin
        check("req", 32'(dmem_req), 32'd1);
        check("addr", dmem_addr, ea_w);
        check("be", 32'(dmem_be), 32'(be));
        check("wdata", dmem_wdata, wd);
        check("done_in_req", 32'(st_done), 32'd0);
        acked = (k == dly);
        dmem_ack = acked;
        @(negedge clk);
        dmem_ack = 0;
        if (acked) break;
      end
      check("done", 32'(st_done), 32'd1);
      check("err", 32'(st_err), 32'(!acked));
      check("req_done", 32'(dmem_req), 32'd0);
      check("be_zero", 32'(dmem_be), 32'd0);
      check("wdata_zero", dmem_wdata, 32'd0);
    end
    st_valid = 0;
    @(negedge clk);
    check("done_pulse", 32'(st_done), 32'd0);
    check("ready_back", 32'(st_ready), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(st_ready), 32'd1);
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_done", 32'(st_done), 32'd0);
    check("rst_err", 32'(st_err), 32'd0);
    rst = 0;

    do_store(`SB, 32'h1000, 32'hA5, 12'h003, 0);
    do_store(`SH, 32'h2000, 32'h1234, 12'hFFE, 0);
    do_store(`SW, 32'h3000, 32'hDEADBEEF, 12'h000, 1);
    do_store(`SB, 32'hFFFFFFFF, 32'h5A, 12'h001, 0);
    do_store(`SW, 32'h4000, 32'h11223344, 12'h010, 99);
    do_store(`SW, 32'h1000, 32'hCAFEF00D, 12'h002, 0);
    do_store(`SH, 32'h1000, 32'hBEEF, 12'h001, 2);
    do_store(`STR_NOP, 32'h1000, 32'h1, 12'h0, 0);
    do_store(3'b111, 32'h1000, 32'h1, 12'h0, 0);

    // Reset while REQ is held, then a stray ack with no request pending.
    @(negedge clk);
    st_valid = 1; store_control = `SB; rs1_data = 32'h40; imm = 12'h001; rs2_data = 32'h77;
    @(negedge clk);
    st_valid = 0;
    check("rstmid_req1", 32'(dmem_req), 32'd1);
    @(negedge clk);
    check("rstmid_req2", 32'(dmem_req), 32'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("rstmid_req_off", 32'(dmem_req), 32'd0);
    check("rstmid_no_done", 32'(st_done), 32'd0);
    check("rstmid_be", 32'(dmem_be), 32'd0);
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
    check("late_ack_done", 32'(st_done), 32'd0);
    check("late_ack_req", 32'(dmem_req), 32'd0);
    check("late_ack_ready", 32'(st_ready), 32'd1);
    @(negedge clk);
    check("late_ack_done2", 32'(st_done), 32'd0);
    do_store(`SB, 32'h40, 32'h77, 12'h001, 0);

    for (int n = 0; n < 40; n++)
      do_store(3'($urandom_range(0, 4)), $urandom, $urandom, 12'($urandom),
               int'($urandom_range(0, 5)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
